traceback_ctrl: RTL and testbench

TRACEBACK_CTRL -- requirements
Module: traceback_ctrl

---
 rtl/viterbi_pkg.sv | 26 ++
 rtl/traceback_ctrl_if.sv | 35 +++
 rtl/traceback_ctrl_lifo.sv | 22 ++
 rtl/traceback_ctrl.sv | 144 ++++++++++++++
 tb/tb_traceback_ctrl.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/viterbi_pkg.sv
// Shared Viterbi traceback definitions: controller state encoding, trellis
// state width derivation and the predecessor-state rule used during traceback.
package viterbi_pkg;

  typedef enum logic [2:0] {
    TB_FILL = 3'd0,
    TB_RD   = 3'd1,
    TB_USE  = 3'd2,
    TB_EMIT = 3'd3,
    TB_DONE = 3'd4
  } tb_state_e;

  function automatic int calc_state_w(input int data_width);
    return $clog2(data_width);
  endfunction

  // Stepping back one symbol shifts the survivor decision in at the LSB.
  function automatic logic [31:0] pred_state(input logic [31:0] cur,
                                             input logic        dec,
                                             input int          state_w);
    logic [31:0] mask;
    mask = (32'd1 << state_w) - 32'd1;
    return ((cur << 1) | {31'd0, dec}) & mask;
  endfunction

endpackage

// File: rtl/traceback_ctrl_if.sv
// Signal bundle between the traceback controller, the ACS unit, the survivor
// RAM and the decoded-bit sink.
interface traceback_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
);
  logic                  dec_valid;
  logic [DATA_WIDTH-1:0] dec_vec;
  logic                  frame_last;
  logic                  busy;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr_wr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [ADDR_WIDTH-1:0] mem_addr_rd;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  bit_valid;
  logic                  bit_out;
  logic                  bit_last;
  logic                  bit_ready;
  logic                  frame_done;
  logic                  err_ovf;
  logic                  err_len;

  modport slave (
    input  dec_valid, dec_vec, frame_last, mem_rdata, bit_ready,
    output busy, mem_we, mem_addr_wr, mem_wdata, mem_addr_rd,
           bit_valid, bit_out, bit_last, frame_done, err_ovf, err_len
  );

  modport master (
    output dec_valid, dec_vec, frame_last, mem_rdata, bit_ready,
    input  busy, mem_we, mem_addr_wr, mem_wdata, mem_addr_rd,
           bit_valid, bit_out, bit_last, frame_done, err_ovf, err_len
  );
endinterface

// File: rtl/traceback_ctrl_lifo.sv
// Decoded-bit buffer: traceback writes bits at decreasing t, emission reads
// them back at increasing index, so the frame comes out in time order.
module tb_bit_lifo #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic                  wbit_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic                  rbit_o
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0] bits_q;

  always_ff @(posedge clk) begin
    if (we_i) bits_q[waddr_i] <= wbit_i;
  end

  assign rbit_o = bits_q[raddr_i];
endmodule

// File: rtl/traceback_ctrl.sv
// Viterbi traceback controller: stores survivor decisions for one frame, walks
// the trellis back from state 0, then streams the decoded bits minus the tail.
//
// state   | meaning
// TB_FILL | accept decision vectors into the survivor RAM
// TB_RD   | present survivor address t to the RAM
// TB_USE  | record bit u[t], step to the predecessor state
// TB_EMIT | stream u[0..N-1] to the sink
// TB_DONE | pulse frame_done, rewind write pointer
module traceback_ctrl
  import viterbi_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic            clk,
  input  logic            rst,
  traceback_ctrl_if.slave bus
);
  localparam int STATE_W = calc_state_w(DATA_WIDTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] PTR_MAX = '1;
  localparam logic [ADDR_WIDTH:0]   LEN_ONE = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   LEN_SW  = (ADDR_WIDTH + 1)'(STATE_W);

  tb_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] t_q, t_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [STATE_W-1:0]    st_q, st_d;
  logic                  err_ovf_q, err_ovf_d;
  logic                  err_len_q, err_len_d;
  logic                  lifo_we;
  logic                  lifo_bit;
  logic                  last_bit;

  tb_bit_lifo #(.ADDR_WIDTH(ADDR_WIDTH)) u_lifo (
    .clk     (clk),
    .we_i    (lifo_we),
    .waddr_i (t_q),
    .wbit_i  (st_q[STATE_W-1]),
    .raddr_i (idx_q),
    .rbit_o  (lifo_bit)
  );

  // Emission stops after N = L - STATE_W bits; the tail bits are flush zeros.
  assign last_bit = (({1'b0, idx_q} + LEN_SW + LEN_ONE) == len_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= TB_FILL;
      wr_ptr_q  <= '0;
      t_q       <= '0;
      idx_q     <= '0;
      len_q     <= '0;
      st_q      <= '0;
      err_ovf_q <= 1'b0;
      err_len_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      t_q       <= t_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      st_q      <= st_d;
      err_ovf_q <= err_ovf_d;
      err_len_q <= err_len_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    t_d        = t_q;
    idx_d      = idx_q;
    len_d      = len_q;
    st_d       = st_q;
    err_ovf_d  = err_ovf_q;
    err_len_d  = err_len_q;
    lifo_we    = 1'b0;

    bus.busy        = (state_q != TB_FILL);
    bus.mem_we      = 1'b0;
    bus.mem_addr_wr = wr_ptr_q;
    bus.mem_wdata   = bus.dec_vec;
    bus.mem_addr_rd = t_q;
    bus.bit_valid   = 1'b0;
    bus.bit_out     = 1'b0;
    bus.bit_last    = 1'b0;
    bus.frame_done  = 1'b0;
    bus.err_ovf     = err_ovf_q;
    bus.err_len     = err_len_q;

    if (bus.dec_valid && (state_q != TB_FILL)) err_ovf_d = 1'b1;

    case (state_q)
      TB_FILL: begin
        if (bus.dec_valid && !rst) begin
          bus.mem_we = 1'b1;
          wr_ptr_d   = wr_ptr_q + PTR_ONE;
          if (bus.frame_last || (wr_ptr_q == PTR_MAX)) begin
            len_d   = {1'b0, wr_ptr_q} + LEN_ONE;
            t_d     = wr_ptr_q;
            st_d    = '0;
            state_d = TB_RD;
            if (!bus.frame_last) err_len_d = 1'b1;
          end
        end
      end
      TB_RD: begin
        state_d = TB_USE;
      end
      TB_USE: begin
        lifo_we = 1'b1;
        st_d    = STATE_W'(pred_state(32'(st_q), bus.mem_rdata[st_q], STATE_W));
        if (t_q == '0) begin
          idx_d   = '0;
          state_d = (len_q <= LEN_SW) ? TB_DONE : TB_EMIT;
        end else begin
          t_d     = t_q - PTR_ONE;
          state_d = TB_RD;
        end
      end
      TB_EMIT: begin
        bus.bit_valid = 1'b1;
        bus.bit_out   = lifo_bit;
        bus.bit_last  = last_bit;
        if (bus.bit_ready) begin
          if (last_bit) state_d = TB_DONE;
          else          idx_d   = idx_q + PTR_ONE;
        end
      end
      TB_DONE: begin
        bus.frame_done = 1'b1;
        wr_ptr_d       = '0;
        state_d        = TB_FILL;
      end
      default: begin
        state_d = TB_FILL;
      end
    endcase
  end
endmodule

// File: tb/tb_traceback_ctrl.sv
// Randomized bench for traceback_ctrl: frames are decoded by a plain
// trellis-walk model and compared bit by bit against the emitted stream.
module tb_traceback_ctrl;
  localparam int DW   = 8;
  localparam int AW   = 6;
  localparam int SW   = 3;
  localparam int LMAX = 64;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [DW-1:0] fv  [LMAX];
  logic [DW-1:0] ram [LMAX];
  logic exp_ovf = 1'b0;
  logic exp_len = 1'b0;

  always #5 clk = ~clk;

  traceback_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  traceback_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(posedge clk) begin
    if (bus.mem_we) ram[bus.mem_addr_wr] <= bus.mem_wdata;
    bus.mem_rdata <= ram[bus.mem_addr_rd];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_frame(input int len, input int kind, input bit term);
    for (int i = 0; i < len; i++) begin
      fv[i] = (kind == 0) ? 8'h00 : (kind == 1) ? 8'hFF : 8'($urandom);
    end
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      bus.dec_valid  = 1'b1;
      bus.dec_vec    = fv[i];
      bus.frame_last = term && (i == len - 1);
      #1;
      chk("fill_we", 32'(bus.mem_we), 32'd1);
      chk("fill_addr", 32'(bus.mem_addr_wr), 32'(i));
      chk("fill_busy", 32'(bus.busy), 32'd0);
    end
    if (!term) exp_len = 1'b1;
  endtask

  // rdy_mode: 0 always ready, 1 five-cycle stall before the third bit, 2 random
  task automatic collect(input int len, input int rdy_mode, input int ovf_at);
    bit   ub [LMAX];
    int   s, n, acc, cyc, first_cyc, valid_seen, stall;
    bit   done_seen, prev_stalled, rdy;
    logic pb, pl;
    s = 0;
    for (int t = len - 1; t >= 0; t--) begin
      ub[t] = bit'((s >> 2) & 1);
      s = ((s << 1) | int'(fv[t][s])) & 7;
    end
    n = (len > SW) ? len - SW : 0;
    acc = 0; cyc = 0; first_cyc = -1; valid_seen = 0; stall = 0;
    done_seen = 1'b0; prev_stalled = 1'b0; pb = 1'b0; pl = 1'b0;
    while (!done_seen && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      bus.dec_valid  = (cyc == ovf_at);
      bus.dec_vec    = 8'($urandom);
      bus.frame_last = 1'b0;
      case (rdy_mode)
        0:       rdy = 1'b1;
        1:       rdy = !(acc == 2 && stall < 5);
        default: rdy = bit'($urandom_range(0, 1));
      endcase
      if (rdy_mode == 1 && !rdy) stall++;
      bus.bit_ready = rdy;
      #1;
      if (cyc == ovf_at) begin
        chk("ovf_no_write", 32'(bus.mem_we), 32'd0);
        exp_ovf = 1'b1;
      end
      if (bus.bit_valid) begin
        valid_seen++;
        if (first_cyc < 0) first_cyc = cyc;
        if (prev_stalled) begin
          chk("hold_out", 32'(bus.bit_out), 32'(pb));
          chk("hold_last", 32'(bus.bit_last), 32'(pl));
        end
        if (acc < n) chk("bit_out", 32'(bus.bit_out), 32'(ub[acc]));
        else         chk("extra_bit", 32'd1, 32'd0);
        chk("bit_last", 32'(bus.bit_last), 32'(acc == n - 1));
        pb = bus.bit_out;
        pl = bus.bit_last;
        prev_stalled = !rdy;
        if (rdy) acc++;
      end else begin
        prev_stalled = 1'b0;
      end
      if (bus.frame_done) done_seen = 1'b1;
    end
    bus.dec_valid = 1'b0;
    bus.bit_ready = 1'b0;
    chk("frame_done", 32'(done_seen), 32'd1);
    chk("bit_count", 32'(acc), 32'(n));
    if (n > 0) chk("latency", 32'(first_cyc), 32'(2 * len + 1));
    else       chk("no_valid", 32'(valid_seen), 32'd0);
    @(negedge clk);
    #1;
    chk("done_pulse", 32'(bus.frame_done), 32'd0);
    chk("busy_idle", 32'(bus.busy), 32'd0);
    chk("err_ovf", 32'(bus.err_ovf), 32'(exp_ovf));
    chk("err_len", 32'(bus.err_len), 32'(exp_len));
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_valid", 32'(bus.bit_valid), 32'd0);
    chk("rst_out", 32'(bus.bit_out), 32'd0);
    chk("rst_last", 32'(bus.bit_last), 32'd0);
    chk("rst_done", 32'(bus.frame_done), 32'd0);
    chk("rst_ovf", 32'(bus.err_ovf), 32'd0);
    chk("rst_len", 32'(bus.err_len), 32'd0);
  endtask

  initial begin
    int len;
    bit term;
    for (int i = 0; i < LMAX; i++) ram[i] = '0;
    rst            = 1'b1;
    bus.dec_valid  = 1'b0;
    bus.dec_vec    = '0;
    bus.frame_last = 1'b0;
    bus.bit_ready  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;

    drive_frame(10, 0, 1'b1); collect(10, 0, 0);
    drive_frame(10, 1, 1'b1); collect(10, 1, 0);
    drive_frame(20, 2, 1'b1); collect(20, 2, 0);
    drive_frame(3, 2, 1'b1);  collect(3, 0, 0);
    drive_frame(4, 2, 1'b1);  collect(4, 2, 0);
    drive_frame(1, 2, 1'b1);  collect(1, 0, 0);
    drive_frame(64, 2, 1'b0); collect(64, 2, 0);
    drive_frame(12, 2, 1'b1); collect(12, 1, 3);

    // Abandon a frame mid-traceback, then decode a fresh one.
    drive_frame(10, 2, 1'b1);
    @(negedge clk);
    bus.dec_valid  = 1'b0;
    bus.frame_last = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs();
    exp_ovf = 1'b0;
    exp_len = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    drive_frame(15, 2, 1'b1); collect(15, 0, 0);

    for (int k = 0; k < 6; k++) begin
      len  = $urandom_range(1, LMAX);
      term = (len < LMAX) ? 1'b1 : bit'($urandom_range(0, 1));
      drive_frame(len, 2, term);
      collect(len, 2, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
